shift_deser64: RTL and testbench

Receive-side companion to the team's 64-bit load/shift register: a deserializer that collects a most-significant-first stream arriving as 1-bit or 8-bit beats and assembles it into 64-bit words. It sits at the far end of a link driven by a left-shifting transmitter, which shifts by 1 or by 8. A one-entry output buffer with valid/ready handshakes on both sides lets the next word accumulate while the previous one waits.

---
 rtl/shift_deser64_if.sv | 33 +++
 rtl/shift_deser64.sv | 91 +++++++++
 tb/tb_shift_deser64.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_deser64_if.sv
// Beat-in / word-out bus for shift_deser64.
// The flush signal exists only when SHIFT_DESER_FLUSH_EN is defined.
interface shift_deser64_if;
    logic        in_valid;
    logic        in_mode;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [6:0]  out_count;
`ifdef SHIFT_DESER_FLUSH_EN
    logic        flush;

    modport master (
        output in_valid, in_mode, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, out_count
    );
    modport slave (
        input  in_valid, in_mode, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, out_count
    );
`else
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
`endif
endinterface

// File: rtl/shift_deser64.sv
// Deserializer: MSB-first 1-bit/8-bit beats assembled into 64-bit words behind a one-entry output buffer.
// Define SHIFT_DESER_FLUSH_EN to add the partial-word flush input.
module shift_deser64 (
    input  logic           clk,
    input  logic           areset,
    shift_deser64_if.slave bus
);
    // Handshakes: a beat (in_valid && in_ready) or a word (out_valid && out_ready) transfers on the
    // rising edge where both are high; the sender holds valid, payload and in_mode steady until then.

    logic [63:0] r_acc;
    logic [6:0]  r_cnt;
    logic        r_out_valid;
    logic [63:0] r_out_data;
    logic [6:0]  r_out_count;

    logic        w_flush;
    logic        w_room;
    logic        w_accept;
    logic        w_buf_free;
    logic        w_load_full;
    logic        w_load_flush;
    logic [63:0] w_acc_next;
    logic [63:0] w_flush_word;
    logic [6:0]  w_cnt_next;

    // Byte beats need a whole byte of room; a misaligned count stalls them until bit beats realign.
    assign w_room       = bus.in_mode ? (r_cnt <= 7'd56) : (r_cnt < 7'd64);
    assign bus.in_ready = w_room && !w_flush;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_buf_free   = !r_out_valid || bus.out_ready;

    always_comb begin
        w_acc_next = r_acc;
        w_cnt_next = r_cnt;
        if (w_accept) begin
            if (bus.in_mode) begin
                w_acc_next = {r_acc[55:0], bus.in_data};
                w_cnt_next = r_cnt + 7'd8;
            end else begin
                w_acc_next = {r_acc[62:0], bus.in_data[0]};
                w_cnt_next = r_cnt + 7'd1;
            end
        end
    end

    // A full word parks at cnt=64 until the buffer can take it.
    assign w_load_full = (w_cnt_next == 7'd64) && w_buf_free;

`ifdef SHIFT_DESER_FLUSH_EN
    assign w_flush      = bus.flush;
    assign w_load_flush = w_flush && (r_cnt != 7'd0) && (r_cnt != 7'd64) && w_buf_free;
    assign w_flush_word = r_acc << (7'd64 - r_cnt);
`else
    assign w_flush      = 1'b0;
    assign w_load_flush = 1'b0;
    assign w_flush_word = 64'd0;
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_acc       <= 64'd0;
            r_cnt       <= 7'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 64'd0;
            r_out_count <= 7'd0;
        end else begin
            r_acc <= w_acc_next;
            if (w_load_full) begin
                r_out_data  <= w_acc_next;
                r_out_count <= 7'd64;
                r_out_valid <= 1'b1;
                r_cnt       <= 7'd0;
            end else if (w_load_flush) begin
                r_out_data  <= w_flush_word;
                r_out_count <= r_cnt;
                r_out_valid <= 1'b1;
                r_cnt       <= 7'd0;
            end else begin
                r_cnt <= w_cnt_next;
                if (r_out_valid && bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_shift_deser64.sv
// Self-checking bench for shift_deser64: directed scenarios plus randomized streams against a bit-queue model.
module tb_shift_deser64;
    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    shift_deser64_if bus ();
    shift_deser64 dut (.clk(clk), .areset(areset), .bus(bus));

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    int cyc    = 0;
    int got_rd = 0;

    bit          model_bits[$];
    logic [70:0] exp_q[$];
    logic [70:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Words leaving the buffer, sampled just before the edge that transfers them.
    always begin
        @(negedge clk);
        #4;
        if (areset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            got_q.push_back({bus.out_count, bus.out_data});
    end

    // Reference: the stream is a list of bits; every 64 (or a flush) becomes one left-aligned word.
    task automatic model_complete();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < model_bits.size(); i++) w[63-i] = model_bits[i];
        exp_q.push_back({7'(model_bits.size()), w});
        model_bits.delete();
    endtask

    task automatic model_push(input bit m, input logic [7:0] d);
        if (m) begin
            for (int i = 7; i >= 0; i--) model_bits.push_back(d[i]);
        end else begin
            model_bits.push_back(d[0]);
        end
        if (model_bits.size() == 64) model_complete();
    endtask

    task automatic send_beat(input bit m, input logic [7:0] d, input bit rand_ready);
        int t;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_data  = d;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            t++;
            stalls++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_push(m, d);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b0;
`ifdef SHIFT_DESER_FLUSH_EN
        bus.flush = 1'b0;
`endif
        repeat (3) @(negedge clk);
        areset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h, required 0", bus.out_data); end
        checks++; if (bus.out_count !== 7'd0) begin errors++; $display("FAIL reset_out_count: got %0d, required 0", bus.out_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    endtask

    task automatic test_byte_stream();
        logic [7:0] pat [8];
        int c0, t;
        pat = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        @(negedge clk); bus.out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send_beat(1'b1, pat[i], 1'b0);
            if (i == 0) c0 = cyc;
        end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL byte_latency: out_valid=%b, required 1", bus.out_valid); end
        checks++; if (bus.out_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL byte_word: got %h, required 0123456789abcdef", bus.out_data); end
        checks++; if (bus.out_count !== 7'd64) begin errors++; $display("FAIL byte_count: got %0d, required 64", bus.out_count); end
        checks++; if (cyc - c0 != 7) begin errors++; $display("FAIL byte_throughput: %0d cycles for 7 beats, required 7", cyc - c0); end
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 8; i++) send_beat(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        checks++; if (stalls != 0) begin errors++; $display("FAIL byte_bubbles: stalls=%0d, required 0", stalls); end
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin @(posedge clk); #1; t++; end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL byte_sb_count: got %0d words, required %0d", got_q.size(), exp_q.size()); end
        for (int k = got_rd; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL byte_sb_word: got %h, required %h", got_q[k], exp_q[k]); end
        end
        got_rd = got_q.size();
    endtask

    task automatic test_bit_stream();
        int t;
        for (int i = 0; i < 64; i++) send_beat(1'b0, (i == 0) ? 8'h01 : 8'h00, 1'b0);
        checks++; if (bus.out_data !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL bit_word: got %h, required 8000000000000000", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_count !== 7'd64) begin errors++; $display("FAIL bit_valid: valid=%b count=%0d, required 1/64", bus.out_valid, bus.out_count); end
        for (int i = 0; i < 64; i++) send_beat(1'b0, 8'($urandom_range(0, 255)), 1'b0);
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin @(posedge clk); #1; t++; end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bit_sb_count: got %0d words, required %0d", got_q.size(), exp_q.size()); end
        for (int k = got_rd; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bit_sb_word: got %h, required %h", got_q[k], exp_q[k]); end
        end
        got_rd = got_q.size();
    endtask

    task automatic test_backpressure();
        logic [70:0] first;
        int base, t;
        @(negedge clk); bus.out_ready = 1'b0;
        stalls = 0;
        for (int i = 0; i < 16; i++) send_beat(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        checks++; if (stalls != 0) begin errors++; $display("FAIL bp_accept: stalls=%0d, required 0", stalls); end
        first = exp_q[got_rd];
        @(negedge clk);
        bus.in_mode = 1'b0; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_bit: got %b, required 0", bus.in_ready); end
        bus.in_mode = 1'b1; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_byte: got %b, required 0", bus.in_ready); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({bus.out_count, bus.out_data} !== first || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got %b/%h, required 1/%h", bus.out_valid, {bus.out_count, bus.out_data}, first);
        end
        base = got_q.size();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (got_q.size() != base + 1) begin errors++; $display("FAIL bp_drain1: got %0d words, required %0d", got_q.size(), base + 1); end
        @(posedge clk); #1;
        checks++; if (got_q.size() != base + 2) begin errors++; $display("FAIL bp_drain2: got %0d words, required %0d", got_q.size(), base + 2); end
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin @(posedge clk); #1; t++; end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_sb_count: got %0d words, required %0d", got_q.size(), exp_q.size()); end
        for (int k = got_rd; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_sb_word: got %h, required %h", got_q[k], exp_q[k]); end
        end
        got_rd = got_q.size();
    endtask

    task automatic test_misalign();
        int t;
        for (int i = 0; i < 60; i++) send_beat(1'b0, 8'($urandom_range(0, 1)), 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mode = 1'b1; bus.in_data = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL misalign_stall: in_ready=%b, required 0", bus.in_ready); end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(1'b0, 8'($urandom_range(0, 1)), 1'b0);
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin @(posedge clk); #1; t++; end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL misalign_sb_count: got %0d words, required %0d", got_q.size(), exp_q.size()); end
        for (int k = got_rd; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL misalign_sb_word: got %h, required %h", got_q[k], exp_q[k]); end
        end
        got_rd = got_q.size();
    endtask

    task automatic test_reset_mid();
        int t;
        @(negedge clk); bus.out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send_beat(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        @(negedge clk);
        #2 areset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.out_data !== 64'd0 || bus.out_count !== 7'd0) begin errors++; $display("FAIL rstmid_data: got %h/%0d, required 0/0", bus.out_data, bus.out_count); end
        @(negedge clk);
        areset = 1'b0;
        model_bits.delete();
        while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        got_rd = got_q.size();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin @(posedge clk); #1; t++; end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_sb_count: got %0d words, required %0d", got_q.size(), exp_q.size()); end
        for (int k = got_rd; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rstmid_sb_word: got %h, required %h", got_q[k], exp_q[k]); end
        end
        got_rd = got_q.size();
    endtask

    task automatic test_random_mix();
        int t;
        bit m;
        for (int i = 0; i < 300; i++) begin
            m = (model_bits.size() <= 56) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_beat(m, 8'($urandom_range(0, 255)), 1'b1);
        end
        while (model_bits.size() != 0) send_beat(1'b0, 8'($urandom_range(0, 1)), 1'b1);
        @(negedge clk); bus.out_ready = 1'b1;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin @(posedge clk); #1; t++; end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mix_sb_count: got %0d words, required %0d", got_q.size(), exp_q.size()); end
        for (int k = got_rd; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL mix_sb_word: got %h, required %h", got_q[k], exp_q[k]); end
        end
        got_rd = got_q.size();
    endtask

`ifdef SHIFT_DESER_FLUSH_EN
    task automatic test_flush();
        int t;
        @(negedge clk); bus.out_ready = 1'b1;
        send_beat(1'b1, 8'hAA, 1'b0);
        send_beat(1'b1, 8'hBB, 1'b0);
        send_beat(1'b1, 8'hCC, 1'b0);
        @(negedge clk);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_mode = 1'b1; bus.in_data = 8'h11;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b, required 0", bus.in_ready); end
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        model_complete();
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hAABB_CC00_0000_0000) begin
            errors++; $display("FAIL flush_word: got %b/%h, required 1/aabbcc0000000000", bus.out_valid, bus.out_data);
        end
        checks++; if (bus.out_count !== 7'd24) begin errors++; $display("FAIL flush_count: got %0d, required 24", bus.out_count); end
        @(negedge clk); bus.flush = 1'b1;
        @(negedge clk); bus.flush = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: out_valid=%b, required 0", bus.out_valid); end
        @(negedge clk); bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_beat(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        @(negedge clk); bus.flush = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_count !== 7'd64) begin errors++; $display("FAIL flush_wait: got %b/%0d, required 1/64", bus.out_valid, bus.out_count); end
        bus.out_ready = 1'b1;
        @(negedge clk); bus.flush = 1'b0;
        model_complete();
        #1;
        checks++; if (bus.out_count !== 7'd16) begin errors++; $display("FAIL flush_late_count: got %0d, required 16", bus.out_count); end
        t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin @(posedge clk); #1; t++; end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL flush_sb_count: got %0d words, required %0d", got_q.size(), exp_q.size()); end
        for (int k = got_rd; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL flush_sb_word: got %h, required %h", got_q[k], exp_q[k]); end
        end
        got_rd = got_q.size();
    endtask
`endif

    initial begin
        test_reset();
        test_byte_stream();
        test_bit_stream();
        test_backpressure();
        test_misalign();
        test_reset_mid();
        test_random_mix();
`ifdef SHIFT_DESER_FLUSH_EN
        test_flush();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
